// File: rtl/inst_fetch_bridge_pkg.sv
// Shared widths, types and fetch-state encoding for the instruction-fetch bridge.
// No logic here; imported by the bridge and its interface.
package inst_fetch_bridge_pkg;

  localparam int INST_ADDR_W = 32;
  localparam int INST_W      = 32;
  localparam int BYTE_W      = 8;

  typedef logic [INST_ADDR_W-1:0] inst_addr_t;
  typedef logic [INST_W-1:0]      inst_t;
  typedef logic [BYTE_W-1:0]      byte_t;

  typedef enum logic [1:0] {
    FETCH_IDLE = 2'b00,
    FETCH_BUSY = 2'b01,
    FETCH_DONE = 2'b10
  } fetch_state_e;

  // Byte 0 comes from the lowest RAM address and lands in the least significant lane.
  function automatic inst_t pack_le(input byte_t b0, input byte_t b1,
                                    input byte_t b2, input byte_t b3);
    return {b3, b2, b1, b0};
  endfunction

endpackage

// File: rtl/inst_fetch_bridge_if.sv
// Fetch-port and byte-RAM signals of the bridge; slave = bridge side, master = core/RAM side.
// Pure wiring, no latency; the fetch port has no backpressure beyond the rom_rdy_o strobe.
interface inst_fetch_bridge_if #(
  parameter int ADDR_W = 17
);
  import inst_fetch_bridge_pkg::*;

  logic              rom_ce_i;
  inst_addr_t        rom_addr_i;
  inst_t             rom_data_o;
  logic              rom_rdy_o;
  logic [ADDR_W-1:0] mem_a_o;
  logic              mem_rd_o;
  byte_t             mem_din_i;

  modport slave (
    input  rom_ce_i, rom_addr_i, mem_din_i,
    output rom_data_o, rom_rdy_o, mem_a_o, mem_rd_o
  );

  modport master (
    output rom_ce_i, rom_addr_i, mem_din_i,
    input  rom_data_o, rom_rdy_o, mem_a_o, mem_rd_o
  );

endinterface

// File: rtl/inst_fetch_bridge.sv
// Serves 32-bit instruction fetches from a byte-wide sync RAM with a one-word last-fetch buffer.
// Miss: 6 cycles request-to-strobe, hit: 1 cycle; requests arriving mid-fetch are ignored.
module inst_fetch_bridge
  import inst_fetch_bridge_pkg::*;
#(
  parameter int ADDR_W = 17,
  parameter bit HIT_EN = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  inst_fetch_bridge_if.slave bus
);

  localparam int WA_W = ADDR_W - 2;

  fetch_state_e      state_q, state_d;
  logic [1:0]        iss_cnt_q, iss_cnt_d;
  logic [1:0]        cap_cnt_q, cap_cnt_d;
  logic              cap_pend_q, cap_pend_d;
  logic [ADDR_W-1:0] mem_a_q, mem_a_d;
  logic              mem_rd_q, mem_rd_d;
  inst_t             rom_data_q, rom_data_d;
  logic              rom_rdy_q, rom_rdy_d;
  byte_t             byte_q [4];
  byte_t             byte_d [4];
  logic              buf_valid_q, buf_valid_d;
  logic [WA_W-1:0]   buf_addr_q, buf_addr_d;
  inst_t             buf_data_q, buf_data_d;

  logic [WA_W-1:0]   req_wa;
  logic              hit;
  logic              unused_addr_bits;

  assign req_wa           = bus.rom_addr_i[ADDR_W-1:2];
  assign hit              = HIT_EN && buf_valid_q && (req_wa == buf_addr_q);
  assign unused_addr_bits = ^bus.rom_addr_i;

  always_comb begin
    state_d     = state_q;
    iss_cnt_d   = iss_cnt_q;
    cap_cnt_d   = cap_cnt_q;
    // RAM data is valid one cycle after a read strobe.
    cap_pend_d  = mem_rd_q;
    mem_a_d     = mem_a_q;
    mem_rd_d    = 1'b0;
    rom_data_d  = rom_data_q;
    rom_rdy_d   = 1'b0;
    buf_valid_d = buf_valid_q;
    buf_addr_d  = buf_addr_q;
    buf_data_d  = buf_data_q;
    for (int i = 0; i < 4; i++) begin
      byte_d[i] = byte_q[i];
    end

    case (state_q)
      // DONE accepts a new request exactly like IDLE.
      FETCH_IDLE, FETCH_DONE: begin
        state_d = FETCH_IDLE;
        if (bus.rom_ce_i) begin
          if (hit) begin
            rom_rdy_d  = 1'b1;
            rom_data_d = buf_data_q;
          end else begin
            state_d   = FETCH_BUSY;
            mem_a_d   = {req_wa, 2'b00};
            mem_rd_d  = 1'b1;
            iss_cnt_d = 2'd0;
            cap_cnt_d = 2'd0;
          end
        end
      end

      FETCH_BUSY: begin
        if (mem_rd_q && (iss_cnt_q != 2'd3)) begin
          mem_rd_d  = 1'b1;
          mem_a_d   = mem_a_q + ADDR_W'(1);
          iss_cnt_d = iss_cnt_q + 2'd1;
        end
        if (cap_pend_q) begin
          byte_d[cap_cnt_q] = bus.mem_din_i;
          cap_cnt_d         = cap_cnt_q + 2'd1;
          if (cap_cnt_q == 2'd3) begin
            state_d     = FETCH_DONE;
            rom_rdy_d   = 1'b1;
            rom_data_d  = pack_le(byte_q[0], byte_q[1], byte_q[2], bus.mem_din_i);
            buf_valid_d = 1'b1;
            buf_addr_d  = mem_a_q[ADDR_W-1:2];
            buf_data_d  = pack_le(byte_q[0], byte_q[1], byte_q[2], bus.mem_din_i);
          end
        end
      end

      default: state_d = FETCH_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= FETCH_IDLE;
      iss_cnt_q   <= 2'd0;
      cap_cnt_q   <= 2'd0;
      cap_pend_q  <= 1'b0;
      mem_a_q     <= '0;
      mem_rd_q    <= 1'b0;
      rom_data_q  <= '0;
      rom_rdy_q   <= 1'b0;
      buf_valid_q <= 1'b0;
      buf_addr_q  <= '0;
      buf_data_q  <= '0;
      for (int i = 0; i < 4; i++) begin
        byte_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      iss_cnt_q   <= iss_cnt_d;
      cap_cnt_q   <= cap_cnt_d;
      cap_pend_q  <= cap_pend_d;
      mem_a_q     <= mem_a_d;
      mem_rd_q    <= mem_rd_d;
      rom_data_q  <= rom_data_d;
      rom_rdy_q   <= rom_rdy_d;
      buf_valid_q <= buf_valid_d;
      buf_addr_q  <= buf_addr_d;
      buf_data_q  <= buf_data_d;
      for (int i = 0; i < 4; i++) begin
        byte_q[i] <= byte_d[i];
      end
    end
  end

  assign bus.rom_data_o = rom_data_q;
  assign bus.rom_rdy_o  = rom_rdy_q;
  assign bus.mem_a_o    = mem_a_q;
  assign bus.mem_rd_o   = mem_rd_q;

endmodule

// File: tb/tb_inst_fetch_bridge.sv
// Scoreboard bench: stimulus pushes expected RAM addresses and fetch responses with their cycle;
// a negedge monitor pops and compares whenever mem_rd_o or rom_rdy_o is seen.
module tb_inst_fetch_bridge;

  localparam int AW = 17;

  typedef struct {
    int          cyc;
    logic [31:0] val;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  logic [7:0] ram [0:(1<<AW)-1];
  exp_t mem_q [2][$];
  exp_t rdy_q [2][$];

  inst_fetch_bridge_if #(.ADDR_W(AW)) if0 ();
  inst_fetch_bridge_if #(.ADDR_W(AW)) if1 ();

  inst_fetch_bridge #(.ADDR_W(AW), .HIT_EN(1'b1)) u_hit (
    .clk (clk),
    .rst (rst),
    .bus (if0)
  );

  inst_fetch_bridge #(.ADDR_W(AW), .HIT_EN(1'b0)) u_nohit (
    .clk (clk),
    .rst (rst),
    .bus (if1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous byte RAM shared by both instances.
  always @(posedge clk) begin
    if (if0.mem_rd_o) if0.mem_din_i <= ram[if0.mem_a_o];
    if (if1.mem_rd_o) if1.mem_din_i <= ram[if1.mem_a_o];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_chk++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  task automatic mon(input int d, input logic rd, input logic [AW-1:0] a,
                     input logic rdy, input logic [31:0] dat);
    exp_t e;
    if (rd) begin
      if (mem_q[d].size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL dut%0d_mem_unexpected: mem_rd_o high with addr %h at cycle %0d, expected idle",
                 d, a, cyc);
      end else begin
        e = mem_q[d].pop_front();
        chk($sformatf("dut%0d_mem_cycle", d), cyc, e.cyc);
        chk($sformatf("dut%0d_mem_addr", d), 32'(a), e.val);
      end
    end
    if (rdy) begin
      if (rdy_q[d].size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL dut%0d_rdy_unexpected: rom_rdy_o high with data %h at cycle %0d, expected low",
                 d, dat, cyc);
      end else begin
        e = rdy_q[d].pop_front();
        chk($sformatf("dut%0d_rdy_cycle", d), cyc, e.cyc);
        chk($sformatf("dut%0d_rdy_data", d), dat, e.val);
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, if0.mem_rd_o, if0.mem_a_o, if0.rom_rdy_o, if0.rom_data_o);
    mon(1, if1.mem_rd_o, if1.mem_a_o, if1.rom_rdy_o, if1.rom_data_o);
  end

  // Expected traffic for a miss requested in the current cycle; nb < 4 models an aborted fetch.
  task automatic exp_miss(input int d, input logic [AW-1:0] base, input logic [31:0] w, input int nb);
    exp_t e;
    for (int n = 0; n < nb; n++) begin
      e.cyc = cyc + 1 + n;
      e.val = 32'(base + AW'(n));
      mem_q[d].push_back(e);
    end
    if (nb == 4) begin
      e.cyc = cyc + 6;
      e.val = w;
      rdy_q[d].push_back(e);
    end
  endtask

  task automatic exp_hit(input int d, input logic [31:0] w);
    exp_t e;
    e.cyc = cyc + 1;
    e.val = w;
    rdy_q[d].push_back(e);
  endtask

  task automatic drive(input int d, input logic ce, input logic [31:0] a);
    if0.rom_ce_i   = (d == 0) ? ce : 1'b0;
    if0.rom_addr_i = (d == 0) ? a : 32'h0;
    if1.rom_ce_i   = (d == 1) ? ce : 1'b0;
    if1.rom_addr_i = (d == 1) ? a : 32'h0;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      drive(0, 1'b0, 32'h0);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_u0_rdy"},  32'(if0.rom_rdy_o), 32'h0);
    chk({tag, "_u0_data"}, if0.rom_data_o,     32'h0);
    chk({tag, "_u0_rd"},   32'(if0.mem_rd_o),  32'h0);
    chk({tag, "_u0_a"},    32'(if0.mem_a_o),   32'h0);
    chk({tag, "_u1_rdy"},  32'(if1.rom_rdy_o), 32'h0);
    chk({tag, "_u1_rd"},   32'(if1.mem_rd_o),  32'h0);
  endtask

  initial begin
    if0.rom_ce_i   = 1'b0;
    if0.rom_addr_i = 32'h0;
    if1.rom_ce_i   = 1'b0;
    if1.rom_addr_i = 32'h0;
    for (int i = 0; i < (1 << AW); i++) ram[i] = 8'(i * 37 + 11);
    ram[0]  = 8'h13; ram[1]  = 8'h05; ram[2]  = 8'h10; ram[3]  = 8'h00;
    ram[4]  = 8'h11; ram[5]  = 8'h22; ram[6]  = 8'h33; ram[7]  = 8'h44;
    ram[8]  = 8'h55; ram[9]  = 8'h66; ram[10] = 8'h77; ram[11] = 8'h88;
    ram[16] = 8'h78; ram[17] = 8'h56; ram[18] = 8'h34; ram[19] = 8'h12;
    ram[17'h1FFFC] = 8'hEF; ram[17'h1FFFD] = 8'hBE;
    ram[17'h1FFFE] = 8'hAD; ram[17'h1FFFF] = 8'hDE;

    #2 rst = 1'b1;
    #1 chk_reset_outputs("reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    idle(1);

    // Basic miss, then back-to-back hits starting in the DONE cycle (aligned and misaligned).
    exp_miss(0, 17'h0, 32'h00100513, 4);
    drive(0, 1'b1, 32'h0);
    idle(5);
    exp_hit(0, 32'h00100513);
    drive(0, 1'b1, 32'h0);
    exp_hit(0, 32'h00100513);
    drive(0, 1'b1, 32'h2);
    exp_hit(0, 32'h00100513);
    drive(0, 1'b1, 32'h3);
    idle(2);
    chk("hold_rdy_low", 32'(if0.rom_rdy_o), 32'h0);
    chk("hold_data", if0.rom_data_o, 32'h00100513);

    // Address change and ce drop mid-fetch; the new address is a miss issued from DONE.
    exp_miss(0, 17'h4, 32'h44332211, 4);
    drive(0, 1'b1, 32'h4);
    drive(0, 1'b1, 32'h8);
    idle(4);
    exp_miss(0, 17'h8, 32'h88776655, 4);
    drive(0, 1'b1, 32'h8);
    idle(7);
    chk("hold_data_2", if0.rom_data_o, 32'h88776655);

    // Top word of RAM; upper request bits ignored.
    exp_miss(0, 17'h1FFFC, 32'hDEADBEEF, 4);
    drive(0, 1'b1, 32'h0001FFFC);
    idle(5);
    exp_hit(0, 32'hDEADBEEF);
    drive(0, 1'b1, 32'h2001FFFC);
    idle(2);

    // Reset during T+3 of a miss: no strobe, buffer lost.
    exp_miss(0, 17'h4, 32'h0, 2);
    drive(0, 1'b1, 32'h4);
    idle(2);
    rst = 1'b1;
    #1 chk_reset_outputs("midreset");
    @(posedge clk);
    #1 rst = 1'b0;
    idle(8);
    exp_miss(0, 17'h1FFFC, 32'hDEADBEEF, 4);
    drive(0, 1'b1, 32'h1FFFC);
    idle(5);
    exp_miss(0, 17'h4, 32'h44332211, 4);
    drive(0, 1'b1, 32'h4);
    idle(7);

    // Buffer disabled: repeated fetch of the same word always misses.
    exp_miss(1, 17'h10, 32'h12345678, 4);
    drive(1, 1'b1, 32'h10);
    idle(5);
    exp_miss(1, 17'h10, 32'h12345678, 4);
    drive(1, 1'b1, 32'h10);
    idle(8);

    chk("u0_mem_pending", 32'(mem_q[0].size()), 32'h0);
    chk("u0_rdy_pending", 32'(rdy_q[0].size()), 32'h0);
    chk("u1_mem_pending", 32'(mem_q[1].size()), 32'h0);
    chk("u1_rdy_pending", 32'(rdy_q[1].size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
